// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: widths, canonical NOP and the fetch entry payload.
package rv32_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; any depth >= 1, full+pop accepts a push.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy state; flush wins over push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues credited in-order imem requests,
// buffers responses in a prefetch FIFO and drops in-flight responses on redirect.
module fetch_unit #(
   parameter int unsigned     XLEN            = rv32_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int unsigned     FIFO_DEPTH      = 4,
   parameter int unsigned     MAX_OUTSTANDING = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          imem_req_valid,
   input  logic                          imem_req_ready,
   output logic [XLEN-1:0]               imem_req_addr,
   input  logic                          imem_rsp_valid,
   input  logic [rv32_pkg::ILEN-1:0]     imem_rsp_data,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [rv32_pkg::ILEN-1:0]     out_instr,
   output logic [XLEN-1:0]               out_pc,
   output logic [XLEN-1:0]               out_pc_plus4,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   import rv32_pkg::ILEN;

   localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned QCW = $clog2(MAX_OUTSTANDING) + 1;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [OW-1:0]   inflight;
   logic [OW-1:0]   drop;
   logic [31:0]     fifo_credit_use;
   logic [31:0]     mem_credit_use;
   logic            req_fire;
   logic            rsp_fire;
   logic            rsp_keep;
   logic            rsp_drop;
   logic            out_pop;
   logic [XLEN-1:0] rsp_pc;
   entry_t          push_entry;
   entry_t          head;
   logic            fifo_empty;
   logic            fifo_full;
   logic [QCW-1:0]  pcq_count;
   logic            pcq_full;
   logic            pcq_empty;
   logic            unused_fifo_status;

   // Credits: buffer space must cover everything live, memory must not exceed its window.
   assign fifo_credit_use = 32'(fifo_count) + 32'(inflight);
   assign mem_credit_use  = 32'(inflight) + 32'(drop);
   assign imem_req_valid  = !rst && !redirect_valid &&
                            (fifo_credit_use < FIFO_DEPTH) &&
                            (mem_credit_use < MAX_OUTSTANDING);
   assign imem_req_addr   = fetch_pc;
   assign req_fire        = imem_req_valid && imem_req_ready;

   assign rsp_fire = imem_rsp_valid && ((inflight != '0) || (drop != '0));
   assign rsp_drop = rsp_fire && (drop != '0);
   assign rsp_keep = rsp_fire && (drop == '0) && !redirect_valid;

   assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

   assign out_valid    = !fifo_empty && !redirect_valid;
   assign out_pop      = out_valid && out_ready;
   assign out_instr    = head.instr;
   assign out_pc       = head.pc;
   assign out_pc_plus4 = head.pc + XLEN'(4);

   assign unused_fifo_status = ^{fifo_full, pcq_count, pcq_full, pcq_empty};

   // A redirect moves every in-flight request into the drop count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
         inflight <= '0;
         drop     <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         inflight <= '0;
         drop     <= drop + inflight - OW'(rsp_fire);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
         inflight <= inflight + OW'(req_fire) - OW'(rsp_keep);
         drop     <= drop - OW'(rsp_drop);
      end
   end

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_pc_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (req_fire),
      .wdata (fetch_pc),
      .pop   (rsp_fire),
      .rdata (rsp_pc),
      .count (pcq_count),
      .full  (pcq_full),
      .empty (pcq_empty)
   );

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_prefetch (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (rsp_keep),
      .wdata (push_entry),
      .pop   (out_pop),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (inflight == '0) && (drop == '0)))
      else $error("fetch_unit: response with nothing outstanding");

endmodule
